sha256_const_fetch: RTL and testbench

SHA256_CONST_FETCH -- requirements
Module: sha256_const_fetch

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/eeprom_byte_reader.sv | 68 ++++++
 rtl/sha256_const_fetch.sv | 129 ++++++++++++
 tb/tb_sha256_const_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg -- shared EEPROM layout and state encoding for the SHA-256 constant fetcher.
// Revision 1.0
`default_nettype none

package sha256_pkg;

  localparam logic [12:0] H_BASE  = 13'd0;
  localparam logic [12:0] K_BASE  = 13'd32;
  localparam logic [6:0]  H_WORDS = 7'd8;
  localparam logic [6:0]  K_WORDS = 7'd64;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/eeprom_byte_reader.sv
// eeprom_byte_reader -- one SETUP/ACCESS/CAPTURE read cycle per go; back-to-back reads chain from CAPTURE.
// Revision 1.0
`default_nettype none

module eeprom_byte_reader
  import sha256_pkg::*;
#(
  parameter int T_ACC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [12:0] addr,
  input  logic [7:0]  io,
  output logic [12:0] a,
  output logic [7:0]  rd_byte,
  output logic        byte_valid,
  output logic        ce,
  output logic        oe
);

  logic [2:0]  r_state;
  logic [3:0]  r_acc_cnt;
  logic [12:0] r_addr;
  logic        w_selected;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc_cnt <= 4'd0;
      r_addr    <= 13'd0;
    end else begin
      case (r_state)
        // The address register only loads on the way into SETUP, so A never moves under CE low.
        ST_IDLE, ST_CAPTURE: begin
          if (go) begin
            r_addr  <= addr;
            r_state <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_acc_cnt <= 4'd0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (r_acc_cnt == 4'(T_ACC - 1)) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_acc_cnt <= r_acc_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_selected = (r_state == ST_ACCESS) || (r_state == ST_CAPTURE);
  assign ce         = !w_selected;
  assign oe         = !w_selected;
  assign byte_valid = (r_state == ST_CAPTURE);
  assign rd_byte    = io;
  assign a          = r_addr;

endmodule

`default_nettype wire

// File: rtl/sha256_const_fetch.sv
// sha256_const_fetch -- fetches one big-endian SHA-256 H or K constant from an 8K parallel EEPROM.
// Revision 1.0
`default_nettype none

module sha256_const_fetch
  import sha256_pkg::*;
#(
  parameter int          T_ACC  = 2,
  parameter logic [12:0] H_BASE = sha256_pkg::H_BASE,
  parameter logic [12:0] K_BASE = sha256_pkg::K_BASE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SEL,
  input  logic [0:5]  IDX,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [0:31] WORD,
  output logic [0:12] A,
  input  logic [0:7]  IO,
  output logic        CE,
  output logic        OE,
  output logic        WE
);

  // Top-level sequencing: ST_ACCESS covers all four byte reads run by the reader,
  // ST_SETUP is the access-free gap taken by an out-of-range request.
  logic [2:0]  r_state;
  logic        r_sel;
  logic [5:0]  r_idx;
  logic [1:0]  r_cnt;
  logic [0:23] r_buf;
  logic [0:31] r_word;
  logic        r_err;

  logic        w_idle;
  logic        w_sel;
  logic [5:0]  w_idx;
  logic [1:0]  w_byte;
  logic        w_idx_ok;
  logic        w_go;
  logic [12:0] w_addr;
  logic [12:0] w_a;
  logic [7:0]  w_rd_byte;
  logic        w_byte_valid;
  logic        w_ce;
  logic        w_oe;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_sel    = w_idle ? SEL : r_sel;
  assign w_idx    = w_idle ? IDX : r_idx;
  assign w_byte   = w_idle ? 2'd0 : r_cnt + 2'd1;
  assign w_idx_ok = w_sel ? ({1'b0, w_idx} < K_WORDS) : ({1'b0, w_idx} < H_WORDS);
  assign w_addr   = (w_sel ? K_BASE : H_BASE) + {5'd0, w_idx, 2'b00} + {11'd0, w_byte};
  assign w_go     = (w_idle && START && w_idx_ok) ||
                    ((r_state == ST_ACCESS) && w_byte_valid && (r_cnt != 2'd3));

  eeprom_byte_reader #(
    .T_ACC(T_ACC)
  ) u_reader (
    .clk       (CLK),
    .rst       (RST),
    .go        (w_go),
    .addr      (w_addr),
    .io        (IO),
    .a         (w_a),
    .rd_byte   (w_rd_byte),
    .byte_valid(w_byte_valid),
    .ce        (w_ce),
    .oe        (w_oe)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_idx   <= 6'd0;
      r_cnt   <= 2'd0;
      r_buf   <= 24'd0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_sel   <= SEL;
            r_idx   <= IDX;
            r_cnt   <= 2'd0;
            r_state <= w_idx_ok ? ST_ACCESS : ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_err   <= 1'b1;
          r_state <= ST_FINISH;
        end
        ST_ACCESS: begin
          if (w_byte_valid) begin
            case (r_cnt)
              2'd0: r_buf[0:7]   <= w_rd_byte;
              2'd1: r_buf[8:15]  <= w_rd_byte;
              2'd2: r_buf[16:23] <= w_rd_byte;
              default: begin
                r_word  <= {r_buf, w_rd_byte};
                r_err   <= 1'b0;
                r_state <= ST_FINISH;
              end
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = !w_idle;
  assign DONE = (r_state == ST_FINISH);
  assign ERR  = r_err;
  assign WORD = r_word;
  assign A    = w_a;
  assign CE   = w_ce;
  assign OE   = w_oe;
  assign WE   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sha256_const_fetch.sv
// tb_sha256_const_fetch -- vector table plus randomized fetches against an EEPROM and constant-table model.
// Revision 1.0
`default_nettype none

module tb_sha256_const_fetch;

  localparam int T_ACC   = 2;
  localparam int LAT_OK  = 4 * (T_ACC + 2) + 1;
  localparam int LAT_ERR = 2;

  logic        clk = 1'b0;
  logic        rst, start, sel;
  logic [0:5]  idx;
  logic        busy, done, err;
  logic [0:31] word;
  logic [0:12] a;
  logic [0:7]  io;
  logic        ce, oe, we;

  logic [31:0] H_TAB [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [7:0]  mem [8192];
  int          low_cnt = 0;
  int          viol = 0;
  int          done_cnt = 0;
  logic        prev_ce = 1'b1;
  logic [12:0] prev_a = 13'd0;
  logic        mon_en = 1'b0;
  logic [12:0] addr_q [$];

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_word;

  typedef struct {
    logic        sel;
    logic [5:0]  idx;
    logic [31:0] word;
    logic        err;
  } vec_t;
  vec_t vecs [6];

  sha256_const_fetch #(
    .T_ACC (T_ACC),
    .H_BASE(13'd0),
    .K_BASE(13'd32)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .START(start),
    .SEL  (sel),
    .IDX  (idx),
    .BUSY (busy),
    .DONE (done),
    .ERR  (err),
    .WORD (word),
    .A    (a),
    .IO   (io),
    .CE   (ce),
    .OE   (oe),
    .WE   (we)
  );

  always #5 clk = ~clk;

  // EEPROM: data is only valid once CE has been low for the access time.
  always @(posedge clk) low_cnt <= (ce == 1'b0) ? low_cnt + 1 : 0;
  assign io = (!ce && !oe && low_cnt >= T_ACC) ? mem[a] : 8'h5a;

  always @(negedge clk) begin
    if (mon_en) begin
      viol <= viol + ((we !== 1'b1) ? 1 : 0) + ((!ce && !prev_ce && a != prev_a) ? 1 : 0);
      if (!ce && prev_ce) addr_q.push_back(a);
      if (done) done_cnt <= done_cnt + 1;
    end
    prev_ce <= ce;
    prev_a  <= a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_fetch(input logic s, input logic [5:0] i, input bit repulse,
                           input logic [31:0] exp_word, input logic exp_err, input string tag);
    int          qb, db, nf, got_lat;
    logic [31:0] got_word;
    logic        got_err;
    logic [12:0] abase;
    qb = addr_q.size();
    db = done_cnt;
    abase = 13'(s ? 32 : 0) + 13'(4 * i);
    start = 1'b1; sel = s; idx = i;
    @(negedge clk);
    start = 1'b0; sel = 1'($urandom); idx = 6'($urandom);
    got_lat = -1; got_word = 32'd0; got_err = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        got_lat = c; got_word = word; got_err = err;
        break;
      end
      start = repulse && (c == 5);
      if (start) begin sel = 1'($urandom); idx = 6'($urandom); end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(got_lat), 32'(exp_err ? LAT_ERR : LAT_OK));
    check({tag, " word"}, got_word, exp_word);
    check({tag, " err"}, 32'(got_err), 32'(exp_err));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " held_word"}, word, exp_word);
    @(negedge clk);
    @(negedge clk);
    check({tag, " done_count"}, 32'(done_cnt - db), 32'd1);
    nf = addr_q.size() - qb;
    check({tag, " ce_falls"}, 32'(nf), 32'(exp_err ? 0 : 4));
    for (int k = 0; k < nf && k < 4; k++)
      check($sformatf("%s A[%0d]", tag, k), 32'(addr_q[qb + k]), 32'(abase + 13'(k)));
  endtask

  initial begin
    int falls;
    logic pce;
    logic s;
    logic [5:0] i;
    logic e;
    logic [31:0] w;

    for (int j = 0; j < 8192; j++) mem[j] = 8'($urandom);
    for (int j = 0; j < 8; j++)
      for (int b = 0; b < 4; b++) mem[4 * j + b] = H_TAB[j][31 - 8 * b -: 8];
    for (int j = 0; j < 64; j++)
      for (int b = 0; b < 4; b++) mem[32 + 4 * j + b] = K_TAB[j][31 - 8 * b -: 8];

    rst = 1'b1; start = 1'b0; sel = 1'b0; idx = 6'd0;
    repeat (3) @(negedge clk);
    check("rst ce", 32'(ce), 32'd1);
    check("rst oe", 32'(oe), 32'd1);
    check("rst we", 32'(we), 32'd1);
    check("rst a", 32'(a), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst word", word, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    vecs[0] = '{1'b0, 6'd0,  32'h6a09e667, 1'b0};
    vecs[1] = '{1'b1, 6'd0,  32'h428a2f98, 1'b0};
    vecs[2] = '{1'b1, 6'd63, 32'hc67178f2, 1'b0};
    vecs[3] = '{1'b0, 6'd8,  32'hc67178f2, 1'b1};
    vecs[4] = '{1'b0, 6'd7,  32'h5be0cd19, 1'b0};
    vecs[5] = '{1'b0, 6'd63, 32'h5be0cd19, 1'b1};
    for (int v = 0; v < 6; v++) begin
      run_fetch(vecs[v].sel, vecs[v].idx, v == 1, vecs[v].word, vecs[v].err, $sformatf("vec%0d", v));
      last_word = vecs[v].word;
    end

    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom_range(0, 1));
      i = s ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      e = !s && (i > 6'd7);
      w = e ? last_word : (s ? K_TAB[i] : H_TAB[i]);
      run_fetch(s, i, 1'($urandom_range(0, 1)), w, e, $sformatf("rnd%0d", n));
      last_word = w;
    end

    // Leave ERR=1 and a nonzero WORD so the mid-fetch reset visibly clears both.
    run_fetch(1'b0, 6'd9, 1'b0, last_word, 1'b1, "pre_rst");
    start = 1'b1; sel = 1'b0; idx = 6'd3;
    @(negedge clk);
    start = 1'b0;
    falls = 0; pce = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (!ce && pce) falls++;
      pce = ce;
      if (falls == 3 && !ce) break;
      @(negedge clk);
    end
    check("abort reached byte2", 32'(falls), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("abort ce", 32'(ce), 32'd1);
    check("abort oe", 32'(oe), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort word", word, 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort a", 32'(a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_fetch(1'b0, 6'd7, 1'b0, 32'h5be0cd19, 1'b0, "post_rst");

    check("we high and A stable under CE low", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
